// File: rtl/emmc_bist.sv
// Write/read-back pattern generator and checker driving emmc_sm's host interface.
// Each loop writes TOTAL bytes of base+idx, reads them back and counts mismatches.
module emmc_bist #(
    parameter int          BLK_BYTES = 512,
    parameter int          BLK_CNT   = 1,
    parameter int          LOOPS     = 1,
    parameter logic [7:0]  SEED      = 8'h00
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        run_i,
    input  logic        ready_i,
    input  logic        dvalid_i,
    input  logic [7:0]  dat_i,
    output logic        start_o,
    output logic        we_o,
    output logic [7:0]  dat_o,
    output logic [15:0] blk_cnt_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_cnt_o,
    output logic [23:0] first_err_o,
    output logic [15:0] loop_cnt_o
);

    localparam logic [15:0] TOTAL   = 16'(BLK_BYTES * BLK_CNT);
    localparam logic [15:0] LOOPS_W = 16'(LOOPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_START,
        S_WR_DATA,
        S_RD_START,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  base_q, base_d;
    logic [15:0] err_q, err_d;
    logic [23:0] ferr_q, ferr_d;
    logic [15:0] loop_q, loop_d;
    logic        first_q, first_d;

    logic [7:0]  exp_byte;
    logic [15:0] err_add;
    logic [16:0] err_sum;
    logic        loop_end;

    assign exp_byte = base_q + idx_q[7:0];
    assign err_sum  = {1'b0, err_q} + {1'b0, err_add};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        base_d   = base_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        loop_d   = loop_q;
        first_d  = first_q;
        start_o  = 1'b0;
        err_add  = 16'd0;
        loop_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_i && ready_i) begin
                    err_d   = 16'd0;
                    ferr_d  = 24'd0;
                    loop_d  = 16'd0;
                    base_d  = SEED;
                    state_d = S_WR_START;
                end
            end
            S_WR_START: begin
                start_o = 1'b1;
                idx_d   = 16'd0;
                first_d = 1'b1;
                state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                first_d = 1'b0;
                if (dvalid_i && (idx_q != TOTAL)) begin
                    idx_d = idx_q + 16'd1;
                end
                // first cycle masks emmc_sm's late fall of ready
                if (!first_q && ready_i && (idx_q == TOTAL)) begin
                    state_d = S_RD_START;
                end
            end
            S_RD_START: begin
                start_o = 1'b1;
                idx_d   = 16'd0;
                first_d = 1'b1;
                state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                first_d = 1'b0;
                if (dvalid_i) begin
                    if (idx_q < TOTAL) begin
                        if (dat_i != exp_byte) begin
                            err_add = 16'd1;
                        end
                        idx_d = idx_q + 16'd1;
                    end else begin
                        err_add = 16'd1;
                    end
                end
                if (!first_q && ready_i) begin
                    if (idx_q == TOTAL) begin
                        loop_end = 1'b1;
                    end else if (!dvalid_i) begin
                        // command ended early: every missing byte is an error
                        err_add  = TOTAL - idx_q;
                        loop_end = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!run_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_add != 16'd0) begin
            err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (err_q == 16'd0) begin
                ferr_d = {loop_q[7:0], idx_q};
            end
        end

        if (loop_end) begin
            loop_d = loop_q + 16'd1;
            base_d = base_q + 8'd1;
            if (((LOOPS != 0) && ((loop_q + 16'd1) == LOOPS_W)) || !run_i) begin
                state_d = S_DONE;
            end else begin
                state_d = S_WR_START;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 16'd0;
            base_q  <= SEED;
            err_q   <= 16'd0;
            ferr_q  <= 24'd0;
            loop_q  <= 16'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            loop_q  <= loop_d;
            first_q <= first_d;
        end
    end

    assign we_o        = (state_q == S_WR_START) || (state_q == S_WR_DATA);
    assign dat_o       = exp_byte;
    assign blk_cnt_o   = 16'(BLK_CNT);
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = done_o && (err_q == 16'd0);
    assign err_cnt_o   = err_q;
    assign first_err_o = ferr_q;
    assign loop_cnt_o  = loop_q;

endmodule

// File: tb/tb_emmc_bist.sv
// Bench for emmc_bist: a randomized-timing emmc_sm stand-in serves three
// differently configured instances; expectations come from the pattern rules.
module tb_emmc_bist;

    localparam int TOTAL = 512;

    logic        clk = 1'b0;
    logic        nrst_i = 1'b0;
    logic        run = 1'b0;
    logic        ready_i = 1'b1;
    logic        dvalid_i = 1'b0;
    logic [7:0]  dat_i = 8'h00;
    logic [1:0]  sel = 2'd0;
    logic [2:0]  run_w;

    logic        start_w [3];
    logic        we_w    [3];
    logic [7:0]  dat_w   [3];
    logic [15:0] blk_w   [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        pass_w  [3];
    logic [15:0] err_w   [3];
    logic [23:0] ferr_w  [3];
    logic [15:0] loop_w  [3];

    logic        start_o, we_o, busy_o, done_o, pass_o;
    logic [7:0]  dat_o;
    logic [15:0] err_cnt_o, loop_cnt_o, blk_cnt_o;
    logic [23:0] first_err_o;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    assign run_w[0] = run && (sel == 2'd0);
    assign run_w[1] = run && (sel == 2'd1);
    assign run_w[2] = run && (sel == 2'd2);

    emmc_bist #(.BLK_BYTES(512), .BLK_CNT(1), .LOOPS(1), .SEED(8'h00)) u_l1 (
        .clk_i(clk), .nrst_i(nrst_i), .run_i(run_w[0]), .ready_i(ready_i),
        .dvalid_i(dvalid_i), .dat_i(dat_i), .start_o(start_w[0]), .we_o(we_w[0]),
        .dat_o(dat_w[0]), .blk_cnt_o(blk_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
        .pass_o(pass_w[0]), .err_cnt_o(err_w[0]), .first_err_o(ferr_w[0]),
        .loop_cnt_o(loop_w[0]));

    emmc_bist #(.BLK_BYTES(512), .BLK_CNT(1), .LOOPS(3), .SEED(8'hFE)) u_l3 (
        .clk_i(clk), .nrst_i(nrst_i), .run_i(run_w[1]), .ready_i(ready_i),
        .dvalid_i(dvalid_i), .dat_i(dat_i), .start_o(start_w[1]), .we_o(we_w[1]),
        .dat_o(dat_w[1]), .blk_cnt_o(blk_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
        .pass_o(pass_w[1]), .err_cnt_o(err_w[1]), .first_err_o(ferr_w[1]),
        .loop_cnt_o(loop_w[1]));

    emmc_bist #(.BLK_BYTES(512), .BLK_CNT(1), .LOOPS(0), .SEED(8'h5A)) u_l0 (
        .clk_i(clk), .nrst_i(nrst_i), .run_i(run_w[2]), .ready_i(ready_i),
        .dvalid_i(dvalid_i), .dat_i(dat_i), .start_o(start_w[2]), .we_o(we_w[2]),
        .dat_o(dat_w[2]), .blk_cnt_o(blk_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]),
        .pass_o(pass_w[2]), .err_cnt_o(err_w[2]), .first_err_o(ferr_w[2]),
        .loop_cnt_o(loop_w[2]));

    assign start_o     = start_w[sel];
    assign we_o        = we_w[sel];
    assign dat_o       = dat_w[sel];
    assign blk_cnt_o   = blk_w[sel];
    assign busy_o      = busy_w[sel];
    assign done_o      = done_w[sel];
    assign pass_o      = pass_w[sel];
    assign err_cnt_o   = err_w[sel];
    assign first_err_o = ferr_w[sel];
    assign loop_cnt_o  = loop_w[sel];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stand-in for emmc_sm serving one command; read data can be corrupted,
    // padded with extra dvalid pulses, or cut short by shrinking n_bytes.
    task automatic serve(input bit exp_we, input int n_bytes, input int extra,
                         input int bad_idx, input int drop_at, input logic [7:0] base);
        int t;
        logic [7:0] b;
        t = 0;
        while (start_o !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        chk("start_seen", {31'd0, start_o}, 32'd1);
        if (start_o !== 1'b1) return;
        chk("we_at_start", {31'd0, we_o}, {31'd0, exp_we});
        ready_i = 1'b0;
        tick();
        chk("start_one_cycle", {31'd0, start_o}, 32'd0);
        for (int i = 0; i < n_bytes; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (i == drop_at) run = 1'b0;
            b = base + 8'(i);
            if (exp_we) begin
                chk("wr_byte", {24'd0, dat_o}, {24'd0, b});
            end else begin
                dat_i = (i == bad_idx) ? (b ^ 8'h01) : b;
            end
            dvalid_i = 1'b1;
            tick();
            dvalid_i = 1'b0;
        end
        for (int k = 0; k < extra; k++) begin
            dat_i    = 8'($urandom);
            dvalid_i = 1'b1;
            tick();
            dvalid_i = 1'b0;
        end
        repeat ($urandom_range(1, 3)) tick();
        ready_i = 1'b1;
        tick();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_o !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        chk("done", {31'd0, done_o}, 32'd1);
    endtask

    task automatic stop_run();
        run = 1'b0;
        tick();
        chk("idle_done", {31'd0, done_o}, 32'd0);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] base;

        repeat (2) tick();
        nrst_i = 1'b1;
        sel = 2'd0;
        chk("rst_start", {31'd0, start_o}, 32'd0);
        chk("rst_we", {31'd0, we_o}, 32'd0);
        chk("rst_dat", {24'd0, dat_o}, 32'h00);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_pass", {31'd0, pass_o}, 32'd0);
        chk("rst_err", {16'd0, err_cnt_o}, 32'd0);
        chk("rst_ferr", {8'd0, first_err_o}, 32'd0);
        chk("rst_loop", {16'd0, loop_cnt_o}, 32'd0);
        chk("blk_cnt", {16'd0, blk_cnt_o}, 32'd1);
        sel = 2'd1;
        #1;
        chk("rst_dat_seed", {24'd0, dat_o}, 32'hFE);
        sel = 2'd0;
        #1;

        // clean single loop
        run = 1'b1;
        serve(1'b1, TOTAL, 0, -1, -1, 8'h00);
        serve(1'b0, TOTAL, 0, -1, -1, 8'h00);
        wait_done();
        chk("clean_pass", {31'd0, pass_o}, 32'd1);
        chk("clean_err", {16'd0, err_cnt_o}, 32'd0);
        chk("clean_ferr", {8'd0, first_err_o}, 32'd0);
        chk("clean_loop", {16'd0, loop_cnt_o}, 32'd1);
        chk("done_busy", {31'd0, busy_o}, 32'd0);
        stop_run();

        // one corrupted read byte
        run = 1'b1;
        serve(1'b1, TOTAL, 0, -1, -1, 8'h00);
        serve(1'b0, TOTAL, 0, 300, -1, 8'h00);
        wait_done();
        chk("corrupt_err", {16'd0, err_cnt_o}, 32'd1);
        chk("corrupt_ferr", {8'd0, first_err_o}, 32'h00012C);
        chk("corrupt_pass", {31'd0, pass_o}, 32'd0);
        stop_run();

        // two overrun dvalid pulses
        run = 1'b1;
        serve(1'b1, TOTAL, 0, -1, -1, 8'h00);
        serve(1'b0, TOTAL, 2, -1, -1, 8'h00);
        wait_done();
        chk("overrun_err", {16'd0, err_cnt_o}, 32'd2);
        stop_run();

        // read ends after 510 bytes
        run = 1'b1;
        serve(1'b1, TOTAL, 0, -1, -1, 8'h00);
        serve(1'b0, TOTAL - 2, 0, -1, -1, 8'h00);
        wait_done();
        chk("short_err", {16'd0, err_cnt_o}, 32'd2);
        chk("short_pass", {31'd0, pass_o}, 32'd0);
        stop_run();

        // three loops starting at 0xFE: bases FE, FF, 00
        sel = 2'd1;
        #1;
        run = 1'b1;
        for (int lp = 0; lp < 3; lp++) begin
            base = 8'hFE + 8'(lp);
            serve(1'b1, TOTAL, 0, -1, -1, base);
            serve(1'b0, TOTAL, 0, -1, -1, base);
        end
        wait_done();
        chk("l3_loop", {16'd0, loop_cnt_o}, 32'd3);
        chk("l3_pass", {31'd0, pass_o}, 32'd1);
        stop_run();

        // endless mode, run dropped inside the fourth loop's write
        sel = 2'd2;
        #1;
        run = 1'b1;
        for (int lp = 0; lp < 4; lp++) begin
            base = 8'h5A + 8'(lp);
            serve(1'b1, TOTAL, 0, -1, (lp == 3) ? 100 : -1, base);
            serve(1'b0, TOTAL, 0, -1, -1, base);
        end
        wait_done();
        chk("l0_loop", {16'd0, loop_cnt_o}, 32'd4);
        chk("l0_pass", {31'd0, pass_o}, 32'd1);
        tick();
        chk("l0_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("l0_idle_done", {31'd0, done_o}, 32'd0);
        chk("l0_hold_loop", {16'd0, loop_cnt_o}, 32'd4);

        // synchronous reset in the middle of a write command
        sel = 2'd0;
        #1;
        run = 1'b1;
        t = 0;
        while (start_o !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        chk("rst_run_start", {31'd0, start_o}, 32'd1);
        ready_i = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            dvalid_i = 1'b1;
            tick();
            dvalid_i = 1'b0;
        end
        nrst_i = 1'b0;
        tick();
        nrst_i = 1'b1;
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_start", {31'd0, start_o}, 32'd0);
        chk("mid_rst_err", {16'd0, err_cnt_o}, 32'd0);
        chk("mid_rst_dat", {24'd0, dat_o}, 32'h00);
        ready_i = 1'b1;
        serve(1'b1, TOTAL, 0, -1, -1, 8'h00);
        serve(1'b0, TOTAL, 0, -1, -1, 8'h00);
        wait_done();
        chk("post_rst_pass", {31'd0, pass_o}, 32'd1);
        chk("post_rst_loop", {16'd0, loop_cnt_o}, 32'd1);
        stop_run();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
